range_sensor_hub: RTL and testbench
===================================

Name: range_sensor_hub

Overview:
- N-channel range-sensor front end for the vehicle controller. It generalises the fixed 9-bit per-direction sensor inputs to NUM_CH channels of DATA_W bits.
- On each sample_tick it snapshots all channels, then scans them one per cycle. Per channel it runs a moving-average filter and a near-obstacle compare with hysteresis. It also finds the nearest channel.
- All results are published atomically with a one-cycle result_valid pulse, ready for the Nios PIO/drive logic.

Parameters:
- NUM_CH, 6, number of sensor channels (2..16)
- DATA_W, 9, bits per range reading
- AVG_LOG2, 2, moving-average depth = 2**AVG_LOG2 (0..4; 0 = no filtering)
- IDX_W, 3, width of min_idx; must be >= clog2(NUM_CH)
- STUCK_LIMIT, 8, consecutive identical raw samples that flag a stuck sensor (used only with STUCK_DETECT_EN)

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  single-cycle strobe that starts a snapshot and scan
- sensor_data  in  NUM_CH*DATA_W  raw readings; channel i occupies [i*DATA_W +: DATA_W]
- near_thresh  in  DATA_W  near-obstacle set threshold
- hyst  in  DATA_W  hysteresis added to near_thresh for the clear threshold
- overrun_clr  in  1  clears the overrun flag
- filt_data  out  NUM_CH*DATA_W  filtered readings, same packing as sensor_data
- near_vec  out  NUM_CH  per-channel near flag
- min_dist  out  DATA_W  smallest filtered reading among eligible channels
- min_idx  out  IDX_W  channel index of min_dist
- result_valid  out  1  one-cycle pulse when new results are published
- busy  out  1  high while a scan is in progress
- overrun  out  1  sticky: a tick arrived while busy
- stuck_vec  out  NUM_CH  per-channel stuck flag

Behaviour:
- Reset values:
  - filt_data all ones; min_dist all ones; min_idx 0.
  - near_vec, result_valid, busy, overrun, stuck_vec: 0.
  - History buffers all ones; per-channel sums = (2**DATA_W-1) << AVG_LOG2.
- FSM states: IDLE, SCAN, PUBLISH.
  - IDLE: on sample_tick, register all of sensor_data into a snapshot, set ch=0, go to SCAN, raise busy.
  - SCAN: process one channel per cycle; after ch = NUM_CH-1, go to PUBLISH.
  - PUBLISH: copy shadow results to the outputs, pulse result_valid, drop busy, return to IDLE.
- Latency: result_valid is asserted exactly NUM_CH+1 cycles after the cycle in which sample_tick is sampled high. The earliest next accepted tick is the cycle after PUBLISH.
- Per channel in SCAN:
  - Circular history per channel with a shared write pointer. The pointer advances once per scan, in PUBLISH.
  - sum += new - oldest; sum width = DATA_W + AVG_LOG2.
  - filt = sum >> AVG_LOG2 (truncating).
  - Near flag: set if filt < near_thresh; cleared if filt >= clr, where clr = near_thresh + hyst saturated at 2**DATA_W-1; otherwise held.
- Min search:
  - Strict less-than compare in ascending channel order, so ties resolve to the lowest index.
  - The running minimum starts at all ones with index 0.
  - If no channel is eligible, or all channels read all ones, the result is min_dist all ones and min_idx 0.
- Outputs change only in PUBLISH. filt_data, near_vec, min_dist, min_idx and stuck_vec update together.
- sample_tick while busy (SCAN or PUBLISH): the tick is ignored and overrun is set.
  - overrun_clr clears overrun.
  - If a set and overrun_clr occur in the same cycle, set wins.
- sample_tick and reset asserted together: reset wins.
- Reset mid-scan: everything returns to reset values, including history and sums. The partial scan is discarded and no result_valid is issued.
- near_thresh and hyst are sampled live during SCAN; software changes them only while busy=0.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- Defined:
  - Per channel, keep the last raw value and a saturating repeat counter, updated in SCAN.
  - stuck[i] sets when STUCK_LIMIT consecutive samples carry an identical raw value. It clears on the first differing sample.
  - Stuck channels are excluded from the min search. Filtering and near_vec for those channels still operate.
- Undefined: no extra storage; stuck_vec is tied to 0 and all channels are eligible for the min search.

Test Plan:
Common setup: NUM_CH=4, DATA_W=9, AVG_LOG2=2, near_thresh=50, hyst=10.
- Reset, then one tick with all channels =100 -> result_valid 5 cycles later; every filt=408 ((511*3+100)>>2); near_vec=0000; min_dist=408; min_idx=0.
- From reset, 4 ticks with ch2=40 and others=300 -> after the 4th: filt2=40, near_vec=0100, min_dist=40, min_idx=2.
- Hysteresis: continue with ch2=55 ×4 -> filt2 goes 43,47,51,55 and near_vec[2] stays 1; then ch2=70 -> filt2=58 (near_vec[2]=1), then 62 (near_vec[2]=0).
- Ties: ch1=ch3=80 and others=200 for 4 ticks -> min_dist=80, min_idx=1.
- Overrun: tick again 2 cycles after a tick -> overrun=1 and exactly one result_valid; overrun_clr with a simultaneous ignored tick -> overrun stays 1; overrun_clr alone -> 0.
- Reset mid-scan:
  - Assert reset during SCAN -> all outputs at reset values; no result_valid.
  - Next tick with all =100 -> filt=408, proving the history was reset.
- With STUCK_DETECT_EN: ch0=10 constant for 8 ticks while others vary (100..200) -> stuck_vec[0]=1 and min_idx is never 0; change ch0 to 11 -> stuck_vec[0]=0 in that publish.

Source files
------------

// File: rtl/range_sensor_hub.sv
// -----------------------------------------------------------------------------
// range_sensor_hub
//
// N-channel range-sensor front end. A sample_tick snapshots every channel,
// then the channels are scanned one per clock. For each channel the scan:
//   - updates a moving-average filter of depth 2**AVG_LOG2,
//   - updates a near-obstacle flag that uses hysteresis,
//   - feeds a running minimum search over the eligible channels.
// All results are gathered in shadow registers and published together in a
// single cycle, marked by a one-cycle result_valid pulse.
//
// Optional feature (compile-time macro STUCK_DETECT_EN):
//   When defined, each channel tracks how many consecutive raw samples held
//   the same value. A channel whose value repeats STUCK_LIMIT times is flagged
//   in stuck_vec and is left out of the minimum search. When the macro is not
//   defined, no extra storage is built and stuck_vec is tied to zero.
//
// Ports:
//   clk_clk       in   system clock
//   reset_reset   in   asynchronous active-high reset
//   sample_tick   in   single-cycle strobe that starts a snapshot and scan
//   sensor_data   in   raw readings, channel i at [i*DATA_W +: DATA_W]
//   near_thresh   in   near-obstacle set threshold
//   hyst          in   hysteresis added to near_thresh for the clear level
//   overrun_clr   in   clears the sticky overrun flag
//   filt_data     out  filtered readings, same packing as sensor_data
//   near_vec      out  per-channel near flag
//   min_dist      out  smallest filtered reading among eligible channels
//   min_idx       out  channel index of min_dist
//   result_valid  out  one-cycle pulse when new results are published
//   busy          out  high while a scan is in progress
//   overrun       out  sticky, a tick arrived while busy
//   stuck_vec     out  per-channel stuck flag
// -----------------------------------------------------------------------------
module range_sensor_hub #(
    parameter int NUM_CH      = 6,
    parameter int DATA_W      = 9,
    parameter int AVG_LOG2    = 2,
    parameter int IDX_W       = 3,
    parameter int STUCK_LIMIT = 8
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic                       sample_tick,
    input  logic [NUM_CH*DATA_W-1:0]   sensor_data,
    input  logic [DATA_W-1:0]          near_thresh,
    input  logic [DATA_W-1:0]          hyst,
    input  logic                       overrun_clr,
    output logic [NUM_CH*DATA_W-1:0]   filt_data,
    output logic [NUM_CH-1:0]          near_vec,
    output logic [DATA_W-1:0]          min_dist,
    output logic [IDX_W-1:0]           min_idx,
    output logic                       result_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [NUM_CH-1:0]          stuck_vec
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int DEPTH = 1 << AVG_LOG2;
    // A depth-1 history still needs a 1-bit pointer; it simply never moves.
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    // Sum of a history that is entirely all-ones.
    localparam logic [SUM_W-1:0]  SUM_RST  = SUM_W'(ALL_ONES) << AVG_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_reg;
    state_t                 state_next;

    logic [CH_W-1:0]        ch_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;

    logic [DATA_W-1:0]      snap_reg   [NUM_CH];
    logic [DATA_W-1:0]      hist_reg   [NUM_CH][DEPTH];
    logic [SUM_W-1:0]       sum_reg    [NUM_CH];

    // Shadow results built up during the scan.
    logic [DATA_W-1:0]      sh_filt_reg [NUM_CH];
    logic [NUM_CH-1:0]      sh_near_reg;
    logic [DATA_W-1:0]      run_min_reg;
    logic [IDX_W-1:0]       run_idx_reg;

    // Published results.
    logic [DATA_W-1:0]      filt_reg   [NUM_CH];
    logic [NUM_CH-1:0]      near_vec_reg;
    logic [DATA_W-1:0]      min_dist_reg;
    logic [IDX_W-1:0]       min_idx_reg;
    logic                   result_valid_reg;
    logic                   busy_reg;
    logic                   overrun_reg;

    // FSM strobes
    logic                   accept_tick;
    logic                   scan_en;
    logic                   publish_en;
    logic                   last_ch;

    // Scan datapath
    logic [DATA_W-1:0]      cur_raw;
    logic [DATA_W-1:0]      cur_old;
    logic [SUM_W-1:0]       sum_new;
    logic [DATA_W-1:0]      filt_new;
    logic [DATA_W:0]        clr_wide;
    logic [DATA_W-1:0]      clr_level;
    logic                   near_new;
    logic [DATA_W-1:0]      base_min;
    logic [IDX_W-1:0]       base_idx;
    logic [DATA_W-1:0]      run_min_next;
    logic [IDX_W-1:0]       run_idx_next;
    logic                   stuck_new;
    logic [PTR_W-1:0]       wr_ptr_next;

    // -------------------------------------------------------------------------
    // FSM: next state and strobes
    // -------------------------------------------------------------------------
    assign last_ch = (ch_reg == CH_W'(NUM_CH - 1));

    always_comb begin
        state_next  = state_reg;
        accept_tick = 1'b0;
        scan_en     = 1'b0;
        publish_en  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (sample_tick) begin
                    accept_tick = 1'b1;
                    state_next  = S_SCAN;
                end
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (last_ch) begin
                    state_next = S_PUBLISH;
                end
            end
            S_PUBLISH: begin
                publish_en = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Scan datapath for the channel selected by ch_reg
    // -------------------------------------------------------------------------
    always_comb begin
        cur_raw  = snap_reg[ch_reg];
        cur_old  = hist_reg[ch_reg][wr_ptr_reg];
        // Modular add/subtract is exact because the true sum always fits.
        sum_new  = sum_reg[ch_reg] + SUM_W'(cur_raw) - SUM_W'(cur_old);
        filt_new = DATA_W'(sum_new >> AVG_LOG2);

        // Clear level saturates instead of wrapping to a small value.
        clr_wide  = {1'b0, near_thresh} + {1'b0, hyst};
        clr_level = clr_wide[DATA_W] ? ALL_ONES : clr_wide[DATA_W-1:0];

        // Set has priority; between the two levels the flag is held.
        near_new = sh_near_reg[ch_reg];
        if (filt_new < near_thresh) begin
            near_new = 1'b1;
        end else if (filt_new >= clr_level) begin
            near_new = 1'b0;
        end

        // Channel 0 restarts the running minimum from the all-ones value.
        base_min = (ch_reg == '0) ? ALL_ONES : run_min_reg;
        base_idx = (ch_reg == '0) ? '0       : run_idx_reg;
        run_min_next = base_min;
        run_idx_next = base_idx;
        // Strict compare in ascending order keeps the lowest index on ties.
        if (!stuck_new && (filt_new < base_min)) begin
            run_min_next = filt_new;
            run_idx_next = IDX_W'(ch_reg);
        end

        wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Main sequential logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg        <= S_IDLE;
            ch_reg           <= '0;
            wr_ptr_reg       <= '0;
            sh_near_reg      <= '0;
            run_min_reg      <= ALL_ONES;
            run_idx_reg      <= '0;
            near_vec_reg     <= '0;
            min_dist_reg     <= ALL_ONES;
            min_idx_reg      <= '0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_reg[i]    <= ALL_ONES;
                sum_reg[i]     <= SUM_RST;
                sh_filt_reg[i] <= ALL_ONES;
                filt_reg[i]    <= ALL_ONES;
                for (int j = 0; j < DEPTH; j++) begin
                    hist_reg[i][j] <= ALL_ONES;
                end
            end
        end else begin
            state_reg        <= state_next;
            result_valid_reg <= publish_en;

            // A tick outside IDLE is dropped; setting beats clearing.
            if (sample_tick && (state_reg != S_IDLE)) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end

            if (accept_tick) begin
                ch_reg   <= '0;
                busy_reg <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    snap_reg[i] <= sensor_data[i*DATA_W +: DATA_W];
                end
            end

            if (scan_en) begin
                hist_reg[ch_reg][wr_ptr_reg] <= cur_raw;
                sum_reg[ch_reg]              <= sum_new;
                sh_filt_reg[ch_reg]          <= filt_new;
                sh_near_reg[ch_reg]          <= near_new;
                run_min_reg                  <= run_min_next;
                run_idx_reg                  <= run_idx_next;
                ch_reg                       <= ch_reg + CH_W'(1);
            end

            if (publish_en) begin
                // The shared pointer moves once per completed scan so every
                // channel sees the same oldest slot during the next scan.
                wr_ptr_reg   <= wr_ptr_next;
                near_vec_reg <= sh_near_reg;
                min_dist_reg <= run_min_reg;
                min_idx_reg  <= run_idx_reg;
                busy_reg     <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    filt_reg[i] <= sh_filt_reg[i];
                end
            end
        end
    end

`ifdef STUCK_DETECT_EN
    // -------------------------------------------------------------------------
    // Stuck-sensor detection
    // rep_cnt counts consecutive identical samples including the latest one;
    // zero means no sample has been seen since reset.
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(STUCK_LIMIT + 1);

    logic [DATA_W-1:0]  last_raw_reg [NUM_CH];
    logic [CNT_W-1:0]   rep_cnt_reg  [NUM_CH];
    logic [NUM_CH-1:0]  sh_stuck_reg;
    logic [NUM_CH-1:0]  stuck_vec_reg;
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   cnt_new;

    always_comb begin
        cur_cnt = rep_cnt_reg[ch_reg];
        cnt_new = CNT_W'(1);
        if ((cur_cnt != '0) && (cur_raw == last_raw_reg[ch_reg])) begin
            cnt_new = (cur_cnt >= CNT_W'(STUCK_LIMIT)) ? cur_cnt : cur_cnt + 1'b1;
        end
        stuck_new = (cnt_new >= CNT_W'(STUCK_LIMIT));
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sh_stuck_reg  <= '0;
            stuck_vec_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                last_raw_reg[i] <= ALL_ONES;
                rep_cnt_reg[i]  <= '0;
            end
        end else begin
            if (scan_en) begin
                last_raw_reg[ch_reg] <= cur_raw;
                rep_cnt_reg[ch_reg]  <= cnt_new;
                sh_stuck_reg[ch_reg] <= stuck_new;
            end
            if (publish_en) begin
                stuck_vec_reg <= sh_stuck_reg;
            end
        end
    end

    assign stuck_vec = stuck_vec_reg;
`else
    assign stuck_new = 1'b0;
    assign stuck_vec = '0;
`endif

    // -------------------------------------------------------------------------
    // Output packing
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_pack
            assign filt_data[gi*DATA_W +: DATA_W] = filt_reg[gi];
        end
    endgenerate

    assign near_vec     = near_vec_reg;
    assign min_dist     = min_dist_reg;
    assign min_idx      = min_idx_reg;
    assign result_valid = result_valid_reg;
    assign busy         = busy_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_range_sensor_hub.sv
// -----------------------------------------------------------------------------
// tb_range_sensor_hub
//
// Directed plus randomized bench for range_sensor_hub with NUM_CH=4.
// Expected results come from a behavioural model: per-channel queues of the
// last 2**AVG_LOG2 raw readings (averaged by plain arithmetic), a hysteresis
// flag, a linear minimum search and, when STUCK_DETECT_EN is defined, a
// queue of the last STUCK_LIMIT raw readings per channel.
// -----------------------------------------------------------------------------
module tb_range_sensor_hub;

    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 9;
    localparam int AVG_LOG2    = 2;
    localparam int IDX_W       = 3;
    localparam int STUCK_LIMIT = 8;
    localparam int DEPTH       = 1 << AVG_LOG2;
    localparam int MAXV        = (1 << DATA_W) - 1;
    localparam int W           = NUM_CH * DATA_W;

`ifdef STUCK_DETECT_EN
    localparam bit STUCK_ON = 1'b1;
`else
    localparam bit STUCK_ON = 1'b0;
`endif

    logic              clk_clk     = 1'b0;
    logic              reset_reset = 1'b1;
    logic              sample_tick = 1'b0;
    logic              overrun_clr = 1'b0;
    logic [W-1:0]      sensor_data = '0;
    logic [DATA_W-1:0] near_thresh = 9'd50;
    logic [DATA_W-1:0] hyst        = 9'd10;
    logic [W-1:0]      filt_data;
    logic [NUM_CH-1:0] near_vec;
    logic [DATA_W-1:0] min_dist;
    logic [IDX_W-1:0]  min_idx;
    logic              result_valid;
    logic              busy;
    logic              overrun;
    logic [NUM_CH-1:0] stuck_vec;

    range_sensor_hub #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .AVG_LOG2    (AVG_LOG2),
        .IDX_W       (IDX_W),
        .STUCK_LIMIT (STUCK_LIMIT)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sample_tick  (sample_tick),
        .sensor_data  (sensor_data),
        .near_thresh  (near_thresh),
        .hyst         (hyst),
        .overrun_clr  (overrun_clr),
        .filt_data    (filt_data),
        .near_vec     (near_vec),
        .min_dist     (min_dist),
        .min_idx      (min_idx),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun),
        .stuck_vec    (stuck_vec)
    );

    always #5 clk_clk = ~clk_clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int                hq   [NUM_CH][$];
    int                rawq [NUM_CH][$];
    bit                near_m [NUM_CH];
    logic [W-1:0]      exp_filt;
    logic [NUM_CH-1:0] exp_near;
    logic [NUM_CH-1:0] exp_stuck;
    int                exp_min;
    int                exp_idx;
    int                tick_no = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int e);
        logic [W-1:0] r;
        r = '0;
        r[0*DATA_W +: DATA_W] = DATA_W'(a);
        r[1*DATA_W +: DATA_W] = DATA_W'(b);
        r[2*DATA_W +: DATA_W] = DATA_W'(c);
        r[3*DATA_W +: DATA_W] = DATA_W'(e);
        return r;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            hq[ch].delete();
            rawq[ch].delete();
            for (int k = 0; k < DEPTH; k++) hq[ch].push_back(MAXV);
            near_m[ch] = 1'b0;
        end
    endtask

    // Apply one accepted sample to the model and compute expected results.
    task automatic model_tick(input logic [W-1:0] d);
        int v, sum, f, clr;
        bit st, eq;
        clr = int'(near_thresh) + int'(hyst);
        if (clr > MAXV) clr = MAXV;
        exp_min = MAXV;
        exp_idx = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            v = int'(d[ch*DATA_W +: DATA_W]);
            hq[ch].push_back(v);
            void'(hq[ch].pop_front());
            sum = 0;
            for (int k = 0; k < hq[ch].size(); k++) sum += hq[ch][k];
            f = sum / DEPTH;
            if (f < int'(near_thresh)) near_m[ch] = 1'b1;
            else if (f >= clr)         near_m[ch] = 1'b0;
            rawq[ch].push_back(v);
            if (rawq[ch].size() > STUCK_LIMIT) void'(rawq[ch].pop_front());
            eq = (rawq[ch].size() == STUCK_LIMIT);
            for (int k = 0; k < rawq[ch].size(); k++) if (rawq[ch][k] != v) eq = 1'b0;
            st = STUCK_ON && eq;
            exp_filt[ch*DATA_W +: DATA_W] = DATA_W'(f);
            exp_near[ch]  = near_m[ch];
            exp_stuck[ch] = st;
            if (!st && f < exp_min) begin
                exp_min = f;
                exp_idx = ch;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [W-1:0] ones;
        ones = '1;
        check({tag, "_filt"},    64'(filt_data),    64'(ones));
        check({tag, "_min"},     64'(min_dist),     64'(MAXV));
        check({tag, "_idx"},     64'(min_idx),      64'(0));
        check({tag, "_near"},    64'(near_vec),     64'(0));
        check({tag, "_rv"},      64'(result_valid), 64'(0));
        check({tag, "_busy"},    64'(busy),         64'(0));
        check({tag, "_overrun"}, 64'(overrun),      64'(0));
        check({tag, "_stuck"},   64'(stuck_vec),    64'(0));
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        @(posedge clk_clk); #1;
        model_reset();
    endtask

    // One tick, optionally with an extra (ignored) tick and/or overrun_clr
    // at cycle offset extra_at / clr_at after the accepted tick.
    task automatic run_tick(input logic [W-1:0] d, input int extra_at, input int clr_at);
        int lat, n_rv;
        sensor_data = d;
        sample_tick = 1'b1;
        @(posedge clk_clk); #1;
        sample_tick = 1'b0;
        model_tick(d);
        tick_no++;
        lat  = -1;
        n_rv = 0;
        for (int c = 1; c <= 12; c++) begin
            sample_tick = (c == extra_at);
            overrun_clr = (c == clr_at);
            @(posedge clk_clk); #1;
            sample_tick = 1'b0;
            overrun_clr = 1'b0;
            if (c == 1) check("busy_in_scan", 64'(busy), 64'(1));
            if (result_valid) begin
                n_rv++;
                if (lat < 0) begin
                    lat = c;
                    check("filt_data", 64'(filt_data), 64'(exp_filt));
                    check("near_vec",  64'(near_vec),  64'(exp_near));
                    check("min_dist",  64'(min_dist),  64'(exp_min));
                    check("min_idx",   64'(min_idx),   64'(exp_idx));
                    check("stuck_vec", 64'(stuck_vec), 64'(exp_stuck));
                end
            end
        end
        check("latency",    64'(lat),  64'(NUM_CH + 1));
        check("rv_pulses",  64'(n_rv), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
        $display("[TB] tick %0d data=%h filt=%h near=%b min=%0d idx=%0d stuck=%b ovr=%0b",
                 tick_no, d, filt_data, near_vec, min_dist, min_idx, stuck_vec, overrun);
    endtask

    function automatic int rval();
        int sel;
        sel = int'($urandom_range(0, 5));
        if (sel == 0) return MAXV;
        if (sel == 1) return int'($urandom_range(30, 33));
        return int'($urandom_range(0, MAXV));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] f408;
        bit rv_seen;

        // ---- Reset state ----
        reset_reset = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        check_reset_outputs("in_reset");
        reset_reset = 1'b0;
        @(posedge clk_clk); #1;
        check_reset_outputs("after_reset");
        model_reset();

        // ---- Single tick, all 100 ----
        f408 = pack4(408, 408, 408, 408);
        run_tick(pack4(100, 100, 100, 100), 0, 0);
        check("first_filt_408", 64'(filt_data), 64'(f408));
        check("first_min_408",  64'(min_dist),  64'(408));

        // ---- Near obstacle on channel 2 ----
        do_reset();
        repeat (4) run_tick(pack4(300, 300, 40, 300), 0, 0);
        check("ch2_filt_40", 64'(filt_data[2*DATA_W +: DATA_W]), 64'(40));
        check("ch2_near",    64'(near_vec), 64'(4'b0100));
        check("ch2_min",     64'(min_dist), 64'(40));
        check("ch2_idx",     64'(min_idx),  64'(2));

        // ---- Hysteresis ----
        repeat (4) run_tick(pack4(300, 300, 55, 300), 0, 0);
        check("hyst_filt_55", 64'(filt_data[2*DATA_W +: DATA_W]), 64'(55));
        check("hyst_hold_55", 64'(near_vec[2]), 64'(1));
        run_tick(pack4(300, 300, 70, 300), 0, 0);
        check("hyst_filt_58", 64'(filt_data[2*DATA_W +: DATA_W]), 64'(58));
        check("hyst_hold_58", 64'(near_vec[2]), 64'(1));
        run_tick(pack4(300, 300, 70, 300), 0, 0);
        check("hyst_filt_62", 64'(filt_data[2*DATA_W +: DATA_W]), 64'(62));
        check("hyst_clr_62",  64'(near_vec[2]), 64'(0));

        // ---- Ties resolve to lowest index ----
        repeat (4) run_tick(pack4(200, 80, 200, 80), 0, 0);
        check("tie_min", 64'(min_dist), 64'(80));
        check("tie_idx", 64'(min_idx),  64'(1));

        // ---- All channels all-ones ----
        repeat (4) run_tick(pack4(MAXV, MAXV, MAXV, MAXV), 0, 0);
        check("ones_min", 64'(min_dist), 64'(MAXV));
        check("ones_idx", 64'(min_idx),  64'(0));

        // ---- Randomized ticks with changing thresholds ----
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) begin
                near_thresh = DATA_W'($urandom_range(0, MAXV));
                hyst        = DATA_W'($urandom_range(0, MAXV));
                if (i == 12) begin
                    near_thresh = 9'd500;
                    hyst        = 9'd100;
                end
            end
            d = pack4(rval(), rval(), rval(), rval());
            run_tick(d, 0, 0);
        end
        near_thresh = 9'd50;
        hyst        = 9'd10;

        // ---- Overrun ----
        do_reset();
        check("ovr_initial", 64'(overrun), 64'(0));
        run_tick(pack4(120, 130, 140, 150), 2, 0);
        check("ovr_set", 64'(overrun), 64'(1));
        run_tick(pack4(125, 135, 145, 155), 3, 3);
        check("ovr_set_wins", 64'(overrun), 64'(1));
        overrun_clr = 1'b1;
        @(posedge clk_clk); #1;
        overrun_clr = 1'b0;
        check("ovr_cleared", 64'(overrun), 64'(0));

        // ---- Reset in the middle of a scan ----
        sensor_data = pack4(20, 30, 40, 50);
        sample_tick = 1'b1;
        @(posedge clk_clk); #1;
        sample_tick = 1'b0;
        @(posedge clk_clk); #1;
        check("midscan_busy", 64'(busy), 64'(1));
        reset_reset = 1'b1;
        #1;
        check_reset_outputs("midscan");
        rv_seen = 1'b0;
        repeat (2) begin
            @(posedge clk_clk); #1;
            rv_seen |= result_valid;
        end
        reset_reset = 1'b0;
        repeat (8) begin
            @(posedge clk_clk); #1;
            rv_seen |= result_valid;
        end
        check("midscan_no_rv", 64'(rv_seen), 64'(0));
        check_reset_outputs("midscan_after");
        model_reset();
        run_tick(pack4(100, 100, 100, 100), 0, 0);
        check("midscan_filt_408", 64'(filt_data), 64'(f408));

        // ---- Stuck channel 0 ----
        do_reset();
        for (int i = 0; i < STUCK_LIMIT; i++) begin
            run_tick(pack4(10, int'($urandom_range(100, 200)), int'($urandom_range(100, 200)),
                           int'($urandom_range(100, 200))), 0, 0);
        end
        check("stuck_set", 64'(stuck_vec[0]), 64'(STUCK_ON));
        run_tick(pack4(11, int'($urandom_range(100, 200)), int'($urandom_range(100, 200)),
                       int'($urandom_range(100, 200))), 0, 0);
        check("stuck_clr", 64'(stuck_vec[0]), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
